// File: rtl/alu_stream_pipe_if.sv
// Operand/result stream bundle for alu_stream_pipe: operand beat in, result beat out.
// The master drives operands and result acceptance; the slave is the ALU pipeline.
interface alu_stream_pipe_if #(
    parameter int NBITS = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS:0]   y;
    logic             co;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, y, co
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, y, co
    );
endinterface

// File: rtl/alu_stream_pipe.sv
// Handshaked ALU pipeline: computes the result ahead of slot 0, then carries it through
// STAGES valid/ready register slots with bubble collapsing and a consumed-result counter.
module alu_stream_pipe #(
    parameter int NBITS    = 8,
    parameter int STAGES   = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_stream_pipe_if.slave    bus,
    output logic [CNT_BITS-1:0] ops_done
);
    localparam int W   = NBITS + 1;
    localparam int SHW = $clog2(NBITS + 1);
    localparam int WW  = W + (1 << SHW) - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MAX = 3'b111;

    logic [W-1:0]       w_y;
    logic               w_co;
    logic [2*NBITS-1:0] w_prod;
    logic [WW-1:0]      w_shl;

    logic [STAGES-1:0]  r_valid;
    logic [W-1:0]       r_y [STAGES];
    logic [STAGES-1:0]  r_co;
    logic [STAGES-1:0]  w_open;
    logic               w_full;

    // The shift is done in a field wide enough for the largest shift amount so that every
    // bit pushed past bit NBITS is still visible for the carry flag.
    always_comb begin
        w_prod = bus.a * bus.b;
        w_shl  = WW'(bus.a) << bus.b[SHW-1:0];
        w_y    = '0;
        w_co   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_y  = {1'b0, bus.a} + {1'b0, bus.b};
                w_co = w_y[NBITS];
            end
            OP_SUB: begin
                w_y  = {1'b0, bus.a} - {1'b0, bus.b};
                w_co = bus.a < bus.b;
            end
            OP_AND: w_y = {1'b0, bus.a & bus.b};
            OP_OR:  w_y = {1'b0, bus.a | bus.b};
            OP_XOR: w_y = {1'b0, bus.a ^ bus.b};
            OP_SHL: begin
                w_y  = w_shl[W-1:0];
                w_co = |w_shl[WW-1:W];
            end
            OP_MUL: begin
                w_y  = w_prod[NBITS:0];
                w_co = |w_prod[2*NBITS-1:NBITS+1];
            end
            OP_MAX: begin
                w_co = bus.a > bus.b;
                w_y  = w_co ? {1'b0, bus.a} : {1'b0, bus.b};
            end
            default: ;
        endcase
    end

    // A slot may load when it, or any slot after it, is empty, or the consumer takes the
    // last result; this is what lets bubbles collapse under a downstream stall.
    always_comb begin
        w_open = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_full = 1'b1;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k) begin
                    w_full = w_full & r_valid[j];
                end
            end
            w_open[k] = bus.out_ready || !w_full;
        end
    end

    assign bus.in_ready  = !rst && w_open[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.y         = r_y[STAGES-1];
    assign bus.co        = r_co[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_co     <= '0;
            ops_done <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_y[k] <= '0;
            end
        end else begin
            if (w_open[0]) begin
                r_valid[0] <= bus.in_valid;
                r_y[0]     <= w_y;
                r_co[0]    <= w_co;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_open[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_y[k]     <= r_y[k-1];
                    r_co[k]    <= r_co[k-1];
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                ops_done <= ops_done + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_stream_pipe.sv
// Self-checking bench for alu_stream_pipe (NBITS=8, STAGES=2): directed steps plus a
// scoreboard queue filled on every accepted operand beat and drained on every consumed result.
module tb_alu_stream_pipe;
    localparam int NBITS    = 8;
    localparam int STAGES   = 2;
    localparam int CNT_BITS = 16;

    typedef struct packed {
        logic [8:0] y;
        logic       co;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [CNT_BITS-1:0] ops_done;
    int                  total = 0;
    int                  bad   = 0;
    exp_t                sbq[$];
    exp_t                eA;

    always #5 clk = ~clk;

    alu_stream_pipe_if #(.NBITS(NBITS)) bus ();

    alu_stream_pipe #(
        .NBITS   (NBITS),
        .STAGES  (STAGES),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .ops_done(ops_done)
    );

    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   r;
        int   sh;
        e = '0;
        case (op)
            0: begin r = a + b; e.y = r[8:0]; e.co = (r > 255); end
            1: begin r = (a - b + 512) % 512; e.y = r[8:0]; e.co = (a < b); end
            2: begin r = a & b; e.y = r[8:0]; end
            3: begin r = a | b; e.y = r[8:0]; end
            4: begin r = a ^ b; e.y = r[8:0]; end
            5: begin
                r  = a;
                sh = b % 16;
                for (int i = 0; i < sh; i++) begin
                    if ((r & 256) != 0) e.co = 1'b1;
                    r = (r << 1) & 511;
                end
                e.y = r[8:0];
            end
            6: begin r = a * b; e.co = (r >= 512); r = r % 512; e.y = r[8:0]; end
            default: begin
                if (a > b) begin r = a; e.co = 1'b1; end
                else       begin r = b; e.co = 1'b0; end
                e.y = r[8:0];
            end
        endcase
        return e;
    endfunction

    // Handshakes seen at the falling edge complete at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                total++;
                assert (sbq.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_extra observed=result expected=none");
                end
                if (sbq.size() > 0) begin
                    total++;
                    assert (bus.y === sbq[0].y && bus.co === sbq[0].co) else begin
                        bad++;
                        $error("FAIL sb_result observed=%h/%b expected=%h/%b",
                               bus.y, bus.co, sbq[0].y, sbq[0].co);
                    end
                    void'(sbq.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(int'(bus.a), int'(bus.b), int'(bus.opcode)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int op, input int a, input int b);
        bus.in_valid = 1'b1;
        bus.opcode   = op[2:0];
        bus.a        = a[7:0];
        bus.b        = b[7:0];
    endtask

    task automatic applyIdle();
        bus.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
            @(negedge clk);
        end
        checkOutput(tag, sbq.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int opsT[10] = '{1, 6, 6, 5, 5, 7, 2, 3, 4, 0};
    int asT[10]  = '{5, 20, 30, 8'h81, 8'h81, 3, 8'hF0, 8'h0C, 8'hFF, 255};
    int bsT[10]  = '{7, 20, 30, 1, 2, 9, 8'h3C, 8'h30, 8'h55, 255};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_ops_done", ops_done, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_y", {bus.co, bus.y}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rel_in_ready", bus.in_ready, 1);

        // single ADD: valid two cycles after presentation
        tick();
        applyStimulus(0, 200, 100);
        tick();
        applyIdle();
        @(negedge clk);
        checkOutput("lat_early", bus.out_valid, 0);
        @(negedge clk);
        checkOutput("lat_valid", bus.out_valid, 1);
        checkOutput("add_y", bus.y, 9'h12C);
        checkOutput("add_co", bus.co, 1);
        waitDrain("add_drain");

        // back-to-back mixed ops
        pulseReset();
        for (int i = 0; i < 10; i++) begin
            tick();
            applyStimulus(opsT[i], asT[i], bsT[i]);
            @(negedge clk);
            if (i >= 2) checkOutput("b2b_valid", bus.out_valid, 1);
        end
        tick();
        applyIdle();
        @(negedge clk);
        checkOutput("b2b_valid8", bus.out_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("b2b_valid9", bus.out_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("b2b_end", bus.out_valid, 0);
        checkOutput("b2b_ops_done", ops_done, 10);

        // backpressure
        eA = model(10, 20, 0);
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(0, 10, 20);
        @(negedge clk);
        checkOutput("bp_rdy0", bus.in_ready, 1);
        tick();
        applyStimulus(1, 3, 50);
        @(negedge clk);
        checkOutput("bp_rdy1", bus.in_ready, 1);
        tick();
        applyStimulus(4, 8'hAA, 8'h0F);
        @(negedge clk);
        checkOutput("bp_full", bus.in_ready, 0);
        checkOutput("bp_valid", bus.out_valid, 1);
        checkOutput("bp_y", bus.y, eA.y);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            checkOutput("bp_hold_rdy", bus.in_ready, 0);
            checkOutput("bp_hold_y", {bus.co, bus.y}, {eA.co, eA.y});
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release", bus.in_ready, 1);
        tick();
        applyIdle();
        waitDrain("bp_drain");

        // bubble collapse under downstream stall
        tick();
        applyStimulus(3, 8'h12, 8'h40);
        tick();
        applyIdle();
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(7, 3, 9);
        @(negedge clk);
        checkOutput("bub_rdy", bus.in_ready, 1);
        checkOutput("bub_valid", bus.out_valid, 1);
        tick();
        applyIdle();
        @(negedge clk);
        checkOutput("bub_full", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b1;
        waitDrain("bub_drain");

        // reset with two beats in flight
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(0, 1, 2);
        tick();
        applyStimulus(0, 3, 4);
        tick();
        rst = 1'b1;
        applyStimulus(0, 5, 6);
        @(negedge clk);
        checkOutput("rst_mid_rdy", bus.in_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("rst_mid_valid", bus.out_valid, 0);
        checkOutput("rst_mid_ops", ops_done, 0);
        tick();
        rst = 1'b0;
        applyIdle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_stale", bus.out_valid, 0);
        end

        // counter wrap
        for (int i = 0; i < 65535; i++) begin
            tick();
            applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)));
        end
        tick();
        applyIdle();
        waitDrain("wrap_drain");
        checkOutput("wrap_max", ops_done, 16'hFFFF);
        tick();
        applyStimulus(6, 30, 30);
        tick();
        applyIdle();
        waitDrain("wrap_drain2");
        checkOutput("wrap_zero", ops_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
